// File: rtl/vip_axi4_rd_mem_responder_if.sv
// ---------------------------------------------------------------------------
// vip_axi4_rd_mem_responder_if
// AXI4 read-channel bundle (AR + R) between a read master and the memory
// responder.
//   AR: arid, araddr, arlen, arsize, arburst, arvalid (m->s), arready (s->m)
//   R : rid, rdata, rresp, rlast, rvalid (s->m), rready (m->s)
// Modports: master (drives AR, accepts R), slave (accepts AR, drives R).
// ---------------------------------------------------------------------------
interface vip_axi4_rd_mem_responder_if #(
  parameter int ID_WIDTH_P   = 4,
  parameter int ADDR_WIDTH_P = 16,
  parameter int DATA_WIDTH_P = 32
);
  logic [ID_WIDTH_P-1:0]   arid;
  logic [ADDR_WIDTH_P-1:0] araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH_P-1:0]   rid;
  logic [DATA_WIDTH_P-1:0] rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/vip_axi4_rd_mem_responder.sv
// ---------------------------------------------------------------------------
// vip_axi4_rd_mem_responder
// AXI4 slave-side read responder backed by an internal word memory.
// One AR burst is accepted at a time. FIXED, INCR and WRAP beat addresses are
// generated, and R beats are returned with RID, RRESP and RLAST.
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   bd_wr_en/addr/data backdoor word write used to preload the memory
//   bus (slave)       AXI4 AR/R channels
// ---------------------------------------------------------------------------
module vip_axi4_rd_mem_responder #(
  parameter int ID_WIDTH_P   = 4,
  parameter int ADDR_WIDTH_P = 16,
  parameter int DATA_WIDTH_P = 32,
  parameter int MEM_DEPTH_P  = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           bd_wr_en,
  input  logic [$clog2(MEM_DEPTH_P)-1:0] bd_addr,
  input  logic [DATA_WIDTH_P-1:0]        bd_data,
  vip_axi4_rd_mem_responder_if.slave     bus
);

  localparam int BYTES_L = DATA_WIDTH_P / 8;
  localparam int SHIFT_L = $clog2(BYTES_L);
  localparam int IDX_W_L = $clog2(MEM_DEPTH_P);
  // Wide enough that the 4KB-crossing sum cannot wrap.
  localparam int EXT_W_L = ADDR_WIDTH_P + 17;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0, BURST_INCR = 2'd1, BURST_WRAP = 2'd2, BURST_RSVD = 2'd3
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY = 2'd0, RESP_EXOKAY = 2'd1, RESP_SLVERR = 2'd2, RESP_DECERR = 2'd3
  } resp_t;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH_P-1:0] mem [MEM_DEPTH_P];

  // Latched request and burst bookkeeping
  logic [ID_WIDTH_P-1:0]   id_q;
  logic [ADDR_WIDTH_P-1:0] addr_q;       // address of the beat on the bus
  logic [7:0]              len_q;
  logic [2:0]              size_q;
  burst_t                  burst_q;
  logic                    slverr_q;
  logic [ADDR_WIDTH_P-1:0] wrap_lo_q;
  logic [ADDR_WIDTH_P-1:0] wrap_bytes_q;
  logic [7:0]              beat_q;

  // Registered channel outputs
  logic                    arready_q;
  logic                    rvalid_q;
  logic                    rlast_q;
  resp_t                   rresp_q;
  logic [ID_WIDTH_P-1:0]   rid_q;
  logic [DATA_WIDTH_P-1:0] rdata_q;

  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rlast   = rlast_q;
  assign bus.rresp   = rresp_q;
  assign bus.rid     = rid_q;
  assign bus.rdata   = rdata_q;

  logic ar_hs, r_hs;
  assign ar_hs = bus.arvalid & arready_q;
  assign r_hs  = rvalid_q & bus.rready;

  // -------------------------------------------------------------------------
  // Burst geometry and error decision (consumed in ADDR)
  // -------------------------------------------------------------------------
  logic [ADDR_WIDTH_P-1:0] beat_bytes, wrap_bytes, wrap_lo;
  logic [EXT_W_L-1:0]      start_ext, end_ext, line_ext;
  logic                    burst_err;

  assign beat_bytes = ADDR_WIDTH_P'(1) << size_q;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    wrap_bytes = (ADDR_WIDTH_P'(len_q) + ADDR_WIDTH_P'(1)) << size_q;
    wrap_lo    = addr_q & ~(wrap_bytes - ADDR_WIDTH_P'(1));
    start_ext  = EXT_W_L'(addr_q & ~(beat_bytes - ADDR_WIDTH_P'(1)));
    end_ext    = start_ext + ((EXT_W_L'(len_q) + EXT_W_L'(1)) << size_q);
    line_ext   = (start_ext & ~EXT_W_L'(12'hFFF)) + EXT_W_L'(13'h1000);
    burst_err  = (size_q > 3'(SHIFT_L));
    case (burst_q)
      BURST_FIXED: if (len_q > 8'd15) burst_err = 1'b1;
      BURST_INCR:  if (end_ext > line_ext) burst_err = 1'b1;
      BURST_WRAP:  if (!(len_q inside {8'd1, 8'd3, 8'd7, 8'd15})) burst_err = 1'b1;
      default:     burst_err = 1'b1;
    endcase
  end

  // -------------------------------------------------------------------------
  // Next beat address
  // -------------------------------------------------------------------------
  logic [ADDR_WIDTH_P-1:0] step_addr;

  always_comb begin
    step_addr = addr_q;
    case (burst_q)
      BURST_INCR: step_addr = (addr_q & ~(beat_bytes - ADDR_WIDTH_P'(1))) + beat_bytes;
      BURST_WRAP: begin
        step_addr = addr_q + beat_bytes;
        if (step_addr == wrap_lo_q + wrap_bytes_q) step_addr = wrap_lo_q;
      end
      default:    step_addr = addr_q;
    endcase
  end

  // -------------------------------------------------------------------------
  // Beat load: first beat after ADDR, or the following beat on a non-final
  // handshake, so consecutive beats run without a bubble.
  // -------------------------------------------------------------------------
  logic                    load_en;
  logic [ADDR_WIDTH_P-1:0] load_addr, load_word;
  logic [7:0]              beat_nxt;
  logic                    load_decerr;

  assign load_en     = (state == ST_DATA) && (!rvalid_q || (r_hs && !rlast_q));
  assign load_addr   = rvalid_q ? step_addr : addr_q;
  assign beat_nxt    = rvalid_q ? beat_q + 8'd1 : 8'd0;
  assign load_word   = load_addr >> SHIFT_L;
  assign load_decerr = ({1'b0, load_word} >= (ADDR_WIDTH_P + 1)'(MEM_DEPTH_P));

  // -------------------------------------------------------------------------
  // FSM next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (ar_hs) state_nxt = ST_ADDR;
      ST_ADDR: state_nxt = ST_DATA;
      ST_DATA: if (r_hs && rlast_q) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State, request latch and R channel registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rid_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state     <= state_nxt;
      // Registered so arready is low in reset and rises one cycle later.
      arready_q <= (state_nxt == ST_IDLE);

      if (ar_hs) begin
        id_q    <= bus.arid;
        addr_q  <= bus.araddr;
        len_q   <= bus.arlen;
        size_q  <= bus.arsize;
        burst_q <= burst_t'(bus.arburst);
      end

      if (state == ST_ADDR) begin
        slverr_q     <= burst_err;
        wrap_lo_q    <= wrap_lo;
        wrap_bytes_q <= wrap_bytes;
      end

      if (load_en) begin
        rvalid_q <= 1'b1;
        addr_q   <= load_addr;
        beat_q   <= beat_nxt;
        rlast_q  <= (beat_nxt == len_q);
        rid_q    <= id_q;
        if (slverr_q) begin
          rdata_q <= '0;
          rresp_q <= RESP_SLVERR;
        end else if (load_decerr) begin
          rdata_q <= '0;
          rresp_q <= RESP_DECERR;
        end else begin
          rdata_q <= mem[load_word[IDX_W_L-1:0]];
          rresp_q <= RESP_OKAY;
        end
      end else if (r_hs) begin
        rvalid_q <= 1'b0;
        rlast_q  <= 1'b0;
      end
    end
  end

  // NOTE: the memory array has no reset; contents survive rst and are only
  // changed by the backdoor. A same-edge read sees the old word.
  always_ff @(posedge clk) begin
    if (bd_wr_en) mem[bd_addr] <= bd_data;
  end

endmodule

// File: tb/tb_vip_axi4_rd_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_vip_axi4_rd_mem_responder
// Directed bench for the AXI4 read memory responder: reset values, INCR and
// WRAP bursts, R backpressure, SLVERR/DECERR cases, the 4KB edge and reset
// in the middle of a burst. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vip_axi4_rd_mem_responder;

  localparam int ID_W  = 4;
  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;

  localparam logic [1:0] OKAY   = 2'd0;
  localparam logic [1:0] SLVERR = 2'd2;
  localparam logic [1:0] DECERR = 2'd3;

  localparam logic [1:0] FIXED = 2'd0;
  localparam logic [1:0] INCR  = 2'd1;
  localparam logic [1:0] WRAP  = 2'd2;
  localparam logic [1:0] RSVD  = 2'd3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bd_wr_en = 1'b0;
  logic [9:0]    bd_addr = '0;
  logic [DW-1:0] bd_data = '0;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_d [16];
  logic [1:0]  exp_r [16];

  vip_axi4_rd_mem_responder_if #(
    .ID_WIDTH_P(ID_W), .ADDR_WIDTH_P(AW), .DATA_WIDTH_P(DW)
  ) bus ();

  vip_axi4_rd_mem_responder #(
    .ID_WIDTH_P(ID_W), .ADDR_WIDTH_P(AW), .DATA_WIDTH_P(DW), .MEM_DEPTH_P(DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bd_wr_en (bd_wr_en),
    .bd_addr  (bd_addr),
    .bd_data  (bd_data),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bd_write(input logic [9:0] idx, input logic [31:0] d);
    bd_wr_en = 1'b1;
    bd_addr  = idx;
    bd_data  = d;
    step();
    bd_wr_en = 1'b0;
  endtask

  task automatic set_exp(input int i, input logic [31:0] d, input logic [1:0] r);
    exp_d[i] = d;
    exp_r[i] = r;
  endtask

  // Issues one AR and checks the two-cycle gap; returns 2 cycles after the
  // handshake edge, when the first beat must be on the bus.
  task automatic do_ar(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst, input string tag);
    int cyc = 0;
    bus.arid    = id;
    bus.araddr  = addr;
    bus.arlen   = len;
    bus.arsize  = size;
    bus.arburst = burst;
    bus.arvalid = 1'b1;
    while (!bus.arready && cyc < 16) begin
      step();
      cyc++;
    end
    check({tag, " arready before AR"}, 64'(bus.arready), 64'(1));
    step();
    bus.arvalid = 1'b0;
    check({tag, " arready low after AR"}, 64'(bus.arready), 64'(0));
    check({tag, " rvalid at AR+0"}, 64'(bus.rvalid), 64'(0));
    step();
    check({tag, " rvalid at AR+1"}, 64'(bus.rvalid), 64'(0));
    step();
  endtask

  // Receives n beats against exp_d/exp_r; toggle alternates rready 1,0,1,0.
  task automatic recv(input int n, input logic [3:0] id, input bit toggle, input string tag);
    int beat = 0;
    int cyc  = 0;
    bit rr   = 1'b1;
    while (beat < n && cyc < 64) begin
      bus.rready = rr;
      check($sformatf("%s rvalid b%0d", tag, beat), 64'(bus.rvalid), 64'(1));
      check($sformatf("%s rdata b%0d", tag, beat), 64'(bus.rdata), 64'(exp_d[beat]));
      check($sformatf("%s rresp b%0d", tag, beat), 64'(bus.rresp), 64'(exp_r[beat]));
      check($sformatf("%s rlast b%0d", tag, beat), 64'(bus.rlast), 64'(beat == n - 1));
      check($sformatf("%s rid b%0d", tag, beat), 64'(bus.rid), 64'(id));
      step();
      cyc++;
      if (rr) beat++;
      if (toggle) rr = !rr;
    end
    bus.rready = 1'b0;
    check({tag, " beats received"}, 64'(beat), 64'(n));
    check({tag, " rvalid after last"}, 64'(bus.rvalid), 64'(0));
    check({tag, " arready after last"}, 64'(bus.arready), 64'(1));
  endtask

  initial begin
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0;
    bus.arburst = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    // Reset values
    step(); step(); step();
    check("rst arready", 64'(bus.arready), 64'(0));
    check("rst rvalid", 64'(bus.rvalid), 64'(0));
    check("rst rlast", 64'(bus.rlast), 64'(0));
    check("rst rresp", 64'(bus.rresp), 64'(OKAY));
    check("rst rid", 64'(bus.rid), 64'(0));
    check("rst rdata", 64'(bus.rdata), 64'(0));
    rst = 1'b0;
    step();
    check("post-rst arready", 64'(bus.arready), 64'(1));
    check("post-rst rvalid", 64'(bus.rvalid), 64'(0));

    // Preload words 0..15 = 0xA0..0xAF, last word = 0x12345678
    for (int i = 0; i < 16; i++) bd_write(10'(i), 32'hA0 + 32'(i));
    bd_write(10'd1023, 32'h1234_5678);

    // INCR 8 beats from 0x0
    for (int i = 0; i < 8; i++) set_exp(i, 32'hA0 + 32'(i), OKAY);
    do_ar(4'd3, 16'h0000, 8'd7, 3'd2, INCR, "incr8");
    recv(8, 4'd3, 1'b0, "incr8");

    // WRAP 4 beats from 0x38: words 14,15,12,13
    set_exp(0, 32'hAE, OKAY);
    set_exp(1, 32'hAF, OKAY);
    set_exp(2, 32'hAC, OKAY);
    set_exp(3, 32'hAD, OKAY);
    do_ar(4'd5, 16'h0038, 8'd3, 3'd2, WRAP, "wrap4");
    recv(4, 4'd5, 1'b0, "wrap4");

    // Backpressure: INCR 4 beats from 0x10, rready 1-0-1-0
    for (int i = 0; i < 4; i++) set_exp(i, 32'hA4 + 32'(i), OKAY);
    do_ar(4'd1, 16'h0010, 8'd3, 3'd2, INCR, "bp4");
    recv(4, 4'd1, 1'b1, "bp4");

    // FIXED 3 beats at 0x14: word 5 repeated
    for (int i = 0; i < 3; i++) set_exp(i, 32'hA5, OKAY);
    do_ar(4'd2, 16'h0014, 8'd2, 3'd2, FIXED, "fixed3");
    recv(3, 4'd2, 1'b0, "fixed3");

    // Reserved burst type -> 2 beats SLVERR, data 0
    for (int i = 0; i < 2; i++) set_exp(i, 32'h0, SLVERR);
    do_ar(4'd7, 16'h0000, 8'd1, 3'd2, RSVD, "rsvd");
    recv(2, 4'd7, 1'b0, "rsvd");

    // Out of range word 1024 -> DECERR
    set_exp(0, 32'h0, DECERR);
    do_ar(4'd4, 16'h1000, 8'd0, 3'd2, INCR, "decerr");
    recv(1, 4'd4, 1'b0, "decerr");

    // Last valid word 1023 -> OKAY
    set_exp(0, 32'h1234_5678, OKAY);
    do_ar(4'd6, 16'h0FFC, 8'd0, 3'd2, INCR, "lastword");
    recv(1, 4'd6, 1'b0, "lastword");

    // Oversized beat (8 bytes on a 4-byte bus) -> SLVERR
    set_exp(0, 32'h0, SLVERR);
    do_ar(4'd8, 16'h0000, 8'd0, 3'd3, INCR, "size");
    recv(1, 4'd8, 1'b0, "size");

    // INCR crossing 4KB line (0xFF8 + 16 bytes) -> SLVERR on all 4 beats
    for (int i = 0; i < 4; i++) set_exp(i, 32'h0, SLVERR);
    do_ar(4'd9, 16'h0FF8, 8'd3, 3'd2, INCR, "4k");
    recv(4, 4'd9, 1'b0, "4k");

    // WRAP with illegal length 3 beats -> SLVERR
    for (int i = 0; i < 3; i++) set_exp(i, 32'h0, SLVERR);
    do_ar(4'd10, 16'h0000, 8'd2, 3'd2, WRAP, "wraplen");
    recv(3, 4'd10, 1'b0, "wraplen");

    // Reset on beat 2 of an 8-beat INCR
    do_ar(4'd11, 16'h0000, 8'd7, 3'd2, INCR, "midrst");
    bus.rready = 1'b1;
    check("midrst beat0", 64'(bus.rdata), 64'(32'hA0));
    step();
    check("midrst beat1", 64'(bus.rdata), 64'(32'hA1));
    step();
    check("midrst beat2", 64'(bus.rdata), 64'(32'hA2));
    check("midrst rvalid before rst", 64'(bus.rvalid), 64'(1));
    rst = 1'b1;
    step();
    check("midrst rvalid after rst", 64'(bus.rvalid), 64'(0));
    check("midrst arready in rst", 64'(bus.arready), 64'(0));
    rst = 1'b0;
    bus.rready = 1'b0;
    step();
    check("midrst arready after rst", 64'(bus.arready), 64'(1));

    // New burst after reset: words 8,9
    set_exp(0, 32'hA8, OKAY);
    set_exp(1, 32'hA9, OKAY);
    do_ar(4'd12, 16'h0020, 8'd1, 3'd2, INCR, "postrst");
    recv(2, 4'd12, 1'b0, "postrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
